// File: rtl/prescaler_pkg.sv
// Shared types and default widths for the multi-channel clock-enable prescaler.
package prescaler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DIV_W_DEF = 8;
  localparam int N_CH_DEF  = 4;

endpackage

// File: rtl/prescaler_channel.sv
// One prescaler channel: divides i_clk by (div+1), continuous or one-shot.
module prescaler_channel
  import prescaler_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_on,
  input  logic             i_oneshot,
  input  logic             i_sync,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_clk_enable,
  output logic             o_busy,
  output logic             o_done
);

  state_e           r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_q;
  logic             w_chg;
  logic             w_tick;

  assign w_chg  = (i_div != r_div_q);
  assign w_tick = (r_cnt == r_div_q);

  // Pulse is masked on the cycle the channel is leaving, reloading or syncing.
  assign o_clk_enable = (r_state == COUNT) & i_on & ~w_chg
                      & w_tick & ~i_sync;
  assign o_busy = (r_state == COUNT);
  assign o_done = (r_state == DONE);

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div_q <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_on) begin
            r_div_q <= i_div;
            r_cnt   <= '0;
            r_state <= COUNT;
          end
        end
        COUNT: begin
          if (!i_on) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_div_q <= '0;
          end else if (w_chg) begin
            r_div_q <= i_div;
            r_cnt   <= '0;
          end else if (i_sync) begin
            r_cnt <= '0;
          end else if (w_tick) begin
            if (i_oneshot) r_state <= DONE;
            else           r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (!i_on) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_div_q <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/clk_prescaler_multi.sv
// N-channel clock-enable prescaler; define PRESCALER_SYNC_EN to add the
// i_sync phase-alignment input shared by all channels.
module clk_prescaler_multi
  import prescaler_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
`ifdef PRESCALER_SYNC_EN
  input  logic                  i_sync,
`endif
  input  logic [N_CH-1:0]       i_on,
  input  logic [N_CH-1:0]       i_oneshot,
  input  logic [N_CH*DIV_W-1:0] i_div,
  output logic [N_CH-1:0]       o_clk_enable,
  output logic [N_CH-1:0]       o_busy,
  output logic [N_CH-1:0]       o_done
);

  logic w_sync;

`ifdef PRESCALER_SYNC_EN
  assign w_sync = i_sync;
`else
  assign w_sync = 1'b0;
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    prescaler_channel #(
      .DIV_W(DIV_W)
    ) u_ch (
      .i_clk       (i_clk),
      .i_arst      (i_arst),
      .i_on        (i_on[c]),
      .i_oneshot   (i_oneshot[c]),
      .i_sync      (w_sync),
      .i_div       (i_div[c*DIV_W +: DIV_W]),
      .o_clk_enable(o_clk_enable[c]),
      .o_busy      (o_busy[c]),
      .o_done      (o_done[c])
    );
  end

endmodule

// File: tb/tb_clk_prescaler_multi.sv
// Directed scoreboard bench for clk_prescaler_multi.
module tb_clk_prescaler_multi;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         arst;
  logic [N-1:0] on;
  logic [N-1:0] os;
  logic [N*W-1:0] div;
  logic         sync;
  logic [N-1:0] ce;
  logic [N-1:0] busy;
  logic [N-1:0] done;

  always #5 clk = ~clk;

  clk_prescaler_multi #(
    .N_CH (N),
    .DIV_W(W)
  ) dut (
    .i_clk       (clk),
    .i_arst      (arst),
`ifdef PRESCALER_SYNC_EN
    .i_sync      (sync),
`endif
    .i_on        (on),
    .i_oneshot   (os),
    .i_div       (div),
    .o_clk_enable(ce),
    .o_busy      (busy),
    .o_done      (done)
  );

  typedef struct {
    string      tag;
    int         ch;
    logic [2:0] exp;
  } item_t;

  item_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic exp_ch(input string tag, input int ch,
                        input logic e_ce, input logic e_busy,
                        input logic e_done);
    item_t it;
    it.tag = tag;
    it.ch  = ch;
    it.exp = {e_ce, e_busy, e_done};
    sb.push_back(it);
  endtask

  task automatic cmp();
    item_t      it;
    logic [2:0] obs;
    #2;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      obs = {ce[it.ch], busy[it.ch], done[it.ch]};
      checks++;
      assert (obs === it.exp) else begin
        failures++;
        $error("FAIL %s ch%0d observed=%b expected=%b (ce,busy,done)",
               it.tag, it.ch, obs, it.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(input int c, input logic [W-1:0] v);
    div[c*W +: W] = v;
  endtask

  initial begin
    arst = 1'b1;
    on   = '0;
    os   = '0;
    div  = '0;
    sync = 1'b0;
    tick();
    tick();
    for (int c = 0; c < N; c++) exp_ch("reset", c, 0, 0, 0);
    cmp();
    arst = 1'b0;

    // ch0: D=3 continuous
    set_div(0, 8'd3);
    on[0] = 1'b1;
    exp_ch("ch0_idle", 0, 0, 0, 0);
    cmp();
    tick();
    for (int i = 0; i < 12; i++) begin
      exp_ch("ch0_cont", 0, (i % 4 == 3), 1, 0);
      cmp();
      tick();
    end
    on[0] = 1'b0;
    tick();
    exp_ch("ch0_off", 0, 0, 0, 0);
    cmp();

    // ch1: D=0, every cycle; drop masks at once
    set_div(1, 8'd0);
    on[1] = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      exp_ch("ch1_d0", 1, 1, 1, 0);
      cmp();
      tick();
    end
    on[1] = 1'b0;
    exp_ch("ch1_mask", 1, 0, 1, 0);
    cmp();
    tick();
    exp_ch("ch1_idle", 1, 0, 0, 0);
    cmp();

    // ch2: D=5, change to 2 at cnt=4
    set_div(2, 8'd5);
    on[2] = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_ch("ch2_pre", 2, 0, 1, 0);
      cmp();
      tick();
    end
    set_div(2, 8'd2);
    exp_ch("ch2_chg", 2, 0, 1, 0);
    cmp();
    tick();
    for (int i = 0; i < 9; i++) begin
      exp_ch("ch2_new", 2, (i % 3 == 2), 1, 0);
      cmp();
      tick();
    end
    on[2] = 1'b0;
    tick();

    // ch3: one-shot D=7, then re-arm
    os[3] = 1'b1;
    set_div(3, 8'd7);
    on[3] = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      exp_ch("ch3_shot", 3, (i == 7), 1, 0);
      cmp();
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        set_div(3, 8'd1);
        os[3] = 1'b0;
      end
      exp_ch("ch3_done", 3, 0, 0, 1);
      cmp();
      tick();
    end
    on[3] = 1'b0;
    exp_ch("ch3_drop", 3, 0, 0, 1);
    cmp();
    tick();
    exp_ch("ch3_idle", 3, 0, 0, 0);
    cmp();
    os[3] = 1'b1;
    set_div(3, 8'd7);
    on[3] = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      exp_ch("ch3_rearm", 3, (i == 7), 1, 0);
      cmp();
      tick();
    end
    exp_ch("ch3_done2", 3, 0, 0, 1);
    cmp();
    on = '0;
    tick();
    os = '0;

    // async reset mid-count, D=9, cnt=6
    for (int c = 0; c < N; c++) set_div(c, 8'd9);
    on = '1;
    tick();
    for (int i = 0; i < 6; i++) tick();
    for (int c = 0; c < N; c++) exp_ch("pre_rst", c, 0, 1, 0);
    cmp();
    arst = 1'b1;
    for (int c = 0; c < N; c++) exp_ch("arst_now", c, 0, 0, 0);
    cmp();
    tick();
    for (int c = 0; c < N; c++) exp_ch("arst_hold", c, 0, 0, 0);
    cmp();
    arst = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < N; c++) exp_ch("post_rst", c, (i == 9), 1, 0);
      cmp();
      tick();
    end
    on = '0;
    tick();

`ifdef PRESCALER_SYNC_EN
    set_div(0, 8'd3);
    set_div(1, 8'd3);
    on[0] = 1'b1;
    tick();
    tick();
    on[1] = 1'b1;
    tick();
    tick();
    exp_ch("sync_pre0", 0, 1, 1, 0);
    exp_ch("sync_pre1", 1, 0, 1, 0);
    cmp();
    sync = 1'b1;
    exp_ch("sync_mask0", 0, 0, 1, 0);
    exp_ch("sync_mask1", 1, 0, 1, 0);
    cmp();
    tick();
    sync = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_ch("sync_al0", 0, (i == 3), 1, 0);
      exp_ch("sync_al1", 1, (i == 3), 1, 0);
      cmp();
      tick();
    end
    on = '0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
